io_unit: RTL and testbench

- Downstream consumer of the control decoder's IO_Enable/IO_Selection outputs.
- Executes OUT (0), IN (1) and GETC (2). OUT latches a register value to the board display; IN blocks until the operator presses Enter, then returns the switch value; GETC returns a byte from a one-entry receive buffer, blocking while it is empty.
- Drives Stall to freeze the PC and pipeline while a blocking read is pending.

---
 rtl/io_unit_if.sv | 24 ++
 rtl/io_unit.sv | 190 +++++++++++++++++++
 tb/tb_io_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_unit_if.sv
// io_unit_if: request/response and receive-stream signals between the
// pipeline (decoder side, receive producer) and the IO unit.
interface io_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  io_enable;
  logic [1:0]            io_selection;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  stall;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;

  modport master (
    output io_enable, io_selection, write_data, rx_valid, rx_data,
    input  read_data, stall, rx_ready
  );

  modport slave (
    input  io_enable, io_selection, write_data, rx_valid, rx_data,
    output read_data, stall, rx_ready
  );
endinterface

// File: rtl/io_unit.sv
// io_unit: executes OUT / IN / GETC requests from the control decoder.
// OUT latches a value onto the display register, IN waits for a synchronised
// Enter press and returns the switches, GETC returns a byte from a one-entry
// receive buffer. Stall freezes the pipeline while a blocking read is pending.
// Optional feature macro: IO_TIMEOUT_EN bounds each wait to TIMEOUT_CYCLES and
// returns 0 with a one-cycle Timeout_Flag pulse; without it waits are unbounded
// and Timeout_Flag is constant 0.
module io_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int SW_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  io_unit_if.slave              bus,
  input  logic [SW_WIDTH-1:0]   switches_i,
  input  logic                  enter_btn_i,
  output logic [DATA_WIDTH-1:0] out_display_o,
  output logic                  out_valid_o,
  output logic                  waiting_led_o,
  output logic                  timeout_flag_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    WAIT_RX = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [DATA_WIDTH-1:0] out_display_q, out_display_d;
  logic                  out_valid_q, out_valid_d;
  logic                  timeout_flag_q, timeout_flag_d;
  logic                  enter_sync1_q, enter_sync2_q, enter_prev_q;
  logic                  enter_rise_s;
  logic                  rx_full_q;
  logic [7:0]            rx_byte_q;
  logic                  rx_clear_s;
  logic                  waiting_s;
  logic                  tmo_hit_s;

  assign enter_rise_s = enter_sync2_q & ~enter_prev_q;
  assign waiting_s    = (state_q == WAIT_IN) || (state_q == WAIT_RX);

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] tmo_cnt_q;

  assign tmo_hit_s = waiting_s && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: counts while staying in a wait state, restarts on any state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else if (waiting_s && (state_d == state_q)) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Enter button: two-flop synchroniser plus previous-value register for edge detect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enter_sync1_q <= 1'b0;
      enter_sync2_q <= 1'b0;
      enter_prev_q  <= 1'b0;
    end else begin
      enter_sync1_q <= enter_btn_i;
      enter_sync2_q <= enter_sync1_q;
      enter_prev_q  <= enter_sync2_q;
    end
  end

  // One-entry receive buffer: a capture empties it, otherwise load when offered and empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
    end else if (rx_clear_s) begin
      rx_full_q <= 1'b0;
    end else if (bus.rx_valid && !rx_full_q) begin
      rx_full_q <= 1'b1;
      rx_byte_q <= bus.rx_data;
    end else begin
      rx_full_q <= rx_full_q;
    end
  end

  // Next-state and register-update decode for the request FSM.
  always_comb begin
    state_d        = state_q;
    read_data_d    = read_data_q;
    out_display_d  = out_display_q;
    out_valid_d    = 1'b0;
    timeout_flag_d = 1'b0;
    rx_clear_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.io_enable) begin
          case (bus.io_selection)
            2'd0: begin
              out_display_d = bus.write_data;
              out_valid_d   = 1'b1;
            end
            2'd1: state_d = WAIT_IN;
            2'd2: begin
              if (rx_full_q) begin
                read_data_d = DATA_WIDTH'(rx_byte_q);
                rx_clear_s  = 1'b1;
                state_d     = RESP;
              end else begin
                state_d = WAIT_RX;
              end
            end
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_IN: begin
        if (!bus.io_enable) begin
          state_d = IDLE;
        end else if (enter_rise_s) begin
          read_data_d = DATA_WIDTH'(switches_i);
          state_d     = RESP;
        end else if (tmo_hit_s) begin
          read_data_d    = '0;
          timeout_flag_d = 1'b1;
          state_d        = RESP;
        end else begin
          state_d = WAIT_IN;
        end
      end
      WAIT_RX: begin
        if (!bus.io_enable) begin
          state_d = IDLE;
        end else if (rx_full_q) begin
          read_data_d = DATA_WIDTH'(rx_byte_q);
          rx_clear_s  = 1'b1;
          state_d     = RESP;
        end else if (tmo_hit_s) begin
          read_data_d    = '0;
          timeout_flag_d = 1'b1;
          state_d        = RESP;
        end else begin
          state_d = WAIT_RX;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      read_data_q    <= '0;
      out_display_q  <= '0;
      out_valid_q    <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_data_q    <= read_data_d;
      out_display_q  <= out_display_d;
      out_valid_q    <= out_valid_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  // Stall covers the request cycle and the wait; the instruction retires in RESP.
  assign bus.stall = !rst_i && bus.io_enable &&
                     ((bus.io_selection == 2'd1) || (bus.io_selection == 2'd2)) &&
                     (state_q != RESP);

  assign bus.read_data  = read_data_q;
  assign bus.rx_ready   = !rx_full_q;
  assign out_display_o  = out_display_q;
  assign out_valid_o    = out_valid_q;
  assign waiting_led_o  = waiting_s;
  assign timeout_flag_o = timeout_flag_q;

endmodule

// File: tb/tb_io_unit.sv
// tb_io_unit: scenario tasks for io_unit; expected read/display values are
// queued when a request is driven and popped when the DUT responds.
module tb_io_unit;
  localparam int DW = 32;
  localparam int SW = 16;
`ifdef IO_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
  localparam int TB_WAIT    = 3;
`else
  localparam int TB_TIMEOUT = 1000;
  localparam int TB_WAIT    = 10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] switches;
  logic          enter;
  logic [DW-1:0] out_display;
  logic          out_valid, waiting_led, timeout_flag;

  always #5 clk = ~clk;

  io_unit_if #(.DATA_WIDTH(DW)) bus();

  io_unit #(.DATA_WIDTH(DW), .SW_WIDTH(SW), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .switches_i(switches),
    .enter_btn_i(enter), .out_display_o(out_display), .out_valid_o(out_valid),
    .waiting_led_o(waiting_led), .timeout_flag_o(timeout_flag)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  // Samples each cycle until Stall drops (RESP) or the budget runs out.
  task automatic wait_resp(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      smp(); n++;
      if (!bus.stall) begin ok = 1'b1; break; end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.io_enable = 1'b1; bus.io_selection = 2'd1;
    repeat (3) @(posedge clk); #1;
    smp();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    checks++; if (bus.read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h want 0", bus.read_data); end
    checks++; if (out_display !== 32'h0) begin errors++; $display("FAIL reset_display: got %h want 0", out_display); end
    checks++; if (out_valid !== 1'b0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", out_valid, timeout_flag); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    checks++; if (waiting_led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", waiting_led); end
    cyc(); rst = 1'b0; bus.io_enable = 1'b0;
  endtask

  task automatic test_out();
    cyc();
    bus.io_enable = 1'b1; bus.io_selection = 2'd0; bus.write_data = 32'h1234;
    exp_q.push_back(32'h1234);
    smp();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL out_stall: got %b want 0", bus.stall); end
    cyc(); bus.io_enable = 1'b0; bus.write_data = 32'hDEAD_BEEF;
    smp();
    exp_v = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid: got %b want 1", out_valid); end
    checks++; if (out_display !== exp_v) begin errors++; $display("FAIL out_display: got %h want %h", out_display, exp_v); end
    cyc(); smp();
    checks++; if (out_valid !== 1'b0 || out_display !== exp_v) begin errors++; $display("FAIL out_after: got %b/%h want 0/%h", out_valid, out_display, exp_v); end
  endtask

  task automatic test_in();
    int n; bit ok; bit bad;
    cyc();
    switches = 16'h00A5; bus.io_enable = 1'b1; bus.io_selection = 2'd1;
    exp_q.push_back(32'h0000_00A5);
    bad = 1'b0;
    for (int k = 0; k < TB_WAIT; k++) begin
      smp();
      if (bus.stall !== 1'b1) bad = 1'b1;
      if (k >= 1 && waiting_led !== 1'b1) bad = 1'b1;
      cyc();
    end
    checks++; if (bad) begin errors++; $display("FAIL in_wait: stall/led dropped before Enter, want 1"); end
    enter = 1'b1;
    wait_resp(8, n, ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || n > 4) begin errors++; $display("FAIL in_latency: got ok=%0d cycles=%0d want ok=1 cycles<=4", ok, n); end
    checks++; if (bus.read_data !== exp_v) begin errors++; $display("FAIL in_read_data: got %h want %h", bus.read_data, exp_v); end
    checks++; if (timeout_flag !== 1'b0 || waiting_led !== 1'b0) begin errors++; $display("FAIL in_resp_flags: got tmo=%b led=%b want 0/0", timeout_flag, waiting_led); end
    cyc(); bus.io_enable = 1'b0; enter = 1'b0; switches = 16'hFFFF;
    smp();
    checks++; if (bus.read_data !== exp_v) begin errors++; $display("FAIL in_hold: got %h want %h", bus.read_data, exp_v); end
    cyc(); cyc();
  endtask

  task automatic test_getc_full();
    int n; bit ok;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
    exp_q.push_back(32'h0000_0041);
    cyc(); bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    smp();
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL getc_full_ready: got %b want 0", bus.rx_ready); end
    cyc(); bus.io_enable = 1'b1; bus.io_selection = 2'd2;
    wait_resp(4, n, ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || n != 2) begin errors++; $display("FAIL getc_full_latency: got ok=%0d cycles=%0d want 1/2", ok, n); end
    checks++; if (bus.read_data !== exp_v) begin errors++; $display("FAIL getc_full_data: got %h want %h", bus.read_data, exp_v); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL getc_full_drain: got %b want 1", bus.rx_ready); end
    cyc(); bus.io_enable = 1'b0;
  endtask

  task automatic test_getc_empty();
    int n; bit ok; bit bad;
    bus.io_enable = 1'b1; bus.io_selection = 2'd2;
    bad = 1'b0;
    for (int k = 0; k < TB_WAIT; k++) begin
      smp();
      if (bus.stall !== 1'b1) bad = 1'b1;
      if (k >= 1 && waiting_led !== 1'b1) bad = 1'b1;
      cyc();
    end
    checks++; if (bad) begin errors++; $display("FAIL getc_empty_wait: stall/led dropped with no data, want 1"); end
    bus.rx_valid = 1'b1; bus.rx_data = 8'h7A;
    exp_q.push_back(32'h0000_007A);
    smp();
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL getc_empty_ready: got %b want 1", bus.rx_ready); end
    cyc(); bus.rx_valid = 1'b0;
    wait_resp(4, n, ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || n != 2) begin errors++; $display("FAIL getc_empty_latency: got ok=%0d cycles=%0d want 1/2", ok, n); end
    checks++; if (bus.read_data !== exp_v) begin errors++; $display("FAIL getc_empty_data: got %h want %h", bus.read_data, exp_v); end
    cyc(); bus.io_enable = 1'b0;
  endtask

  task automatic test_abort_reset();
    cyc(); bus.io_enable = 1'b1; bus.io_selection = 2'd1;
    repeat (3) begin smp(); cyc(); end
    bus.io_enable = 1'b0;
    smp(); cyc(); smp();
    checks++; if (waiting_led !== 1'b0 || bus.read_data !== 32'h0000_007A) begin errors++; $display("FAIL abort: got led=%b data=%h want 0/0000007a", waiting_led, bus.read_data); end
    cyc(); bus.io_enable = 1'b1;
    smp(); cyc(); smp();
    checks++; if (waiting_led !== 1'b1) begin errors++; $display("FAIL rewait_led: got %b want 1", waiting_led); end
    cyc(); rst = 1'b1;
    smp();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got %b want 0", bus.stall); end
    cyc(); rst = 1'b0; bus.io_enable = 1'b0;
    smp();
    checks++; if (bus.read_data !== 32'h0 || out_display !== 32'h0 || waiting_led !== 1'b0 || bus.rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_outputs: got data=%h disp=%h led=%b rdy=%b want 0/0/0/1", bus.read_data, out_display, waiting_led, bus.rx_ready);
    end
    cyc(); enter = 1'b1;
    repeat (5) cyc();
    smp();
    checks++; if (waiting_led !== 1'b0 || bus.read_data !== 32'h0) begin errors++; $display("FAIL enter_ignored: got led=%b data=%h want 0/0", waiting_led, bus.read_data); end
    cyc(); enter = 1'b0; cyc(); cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    int n; bit ok; bit bad;
    switches = 16'h1111; bus.io_enable = 1'b1; bus.io_selection = 2'd1;
    exp_q.push_back(32'h0000_1111);
    repeat (2) begin smp(); cyc(); end
    enter = 1'b1;
    wait_resp(8, n, ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || bus.read_data !== exp_v) begin errors++; $display("FAIL b2b_first: got ok=%0d data=%h want 1/%h", ok, bus.read_data, exp_v); end
    cyc(); smp();
    checks++; if (bus.stall !== 1'b1 || waiting_led !== 1'b0) begin errors++; $display("FAIL b2b_idle: got stall=%b led=%b want 1/0", bus.stall, waiting_led); end
    cyc(); enter = 1'b0; switches = 16'h2222;
    exp_q.push_back(32'h0000_2222);
    bad = 1'b0;
    for (int k = 0; k < TB_WAIT; k++) begin
      smp();
      if (bus.stall !== 1'b1 || waiting_led !== 1'b1) bad = 1'b1;
      cyc();
    end
    checks++; if (bad) begin errors++; $display("FAIL b2b_needs_edge: completed without fresh Enter, want stall=1"); end
    enter = 1'b1;
    wait_resp(8, n, ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || bus.read_data !== exp_v) begin errors++; $display("FAIL b2b_second: got ok=%0d data=%h want 1/%h", ok, bus.read_data, exp_v); end
    cyc(); bus.io_enable = 1'b0; enter = 1'b0;
    cyc(); cyc(); cyc();
  endtask

`ifdef IO_TIMEOUT_EN
  task automatic test_timeout();
    int waits; int pulses; bit ok;
    waits = 0; pulses = 0; ok = 1'b0;
    bus.io_enable = 1'b1; bus.io_selection = 2'd1;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (waiting_led) waits++;
      if (timeout_flag) pulses++;
      if (!bus.stall) begin ok = 1'b1; break; end
      cyc();
    end
    checks++; if (!ok || waits != TB_TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got ok=%0d waits=%0d want 1/%0d", ok, waits, TB_TIMEOUT); end
    checks++; if (bus.read_data !== 32'h0 || timeout_flag !== 1'b1) begin errors++; $display("FAIL timeout_resp: got data=%h flag=%b want 0/1", bus.read_data, timeout_flag); end
    cyc(); bus.io_enable = 1'b0;
    smp();
    if (timeout_flag) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulse: got %0d pulses want 1", pulses); end
    cyc();
  endtask
`endif

  initial begin
    rst = 1'b1; switches = '0; enter = 1'b0;
    bus.io_enable = 1'b0; bus.io_selection = 2'd3; bus.write_data = '0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    test_reset();
    test_out();
    test_in();
    test_getc_full();
    test_getc_empty();
    test_abort_reset();
    test_back_to_back();
`ifdef IO_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
